// File: rtl/morra_pkg.sv
`default_nettype none
// ============================================================================
// Module   : morra_pkg
// Brief    : Move / round / game encodings and sequencer states for the
//            MorraCinese front-end sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package morra_pkg;

    typedef enum logic [1:0] {
        NESSUNA = 2'b00,
        SASSO   = 2'b01,
        CARTA   = 2'b10,
        FORBICE = 2'b11
    } mossa_t;

    typedef enum logic [1:0] {
        MANCHE_NULLA = 2'b00,
        VINCE_P1     = 2'b01,
        VINCE_P2     = 2'b10,
        PAREGGIO     = 2'b11
    } manche_t;

    // Any non-zero game result is final.
    localparam logic [1:0] c_PARTITA_IN_CORSO = 2'b00;

    localparam logic [4:0] c_MANCHE_SAT = 5'd31;

    typedef enum logic [2:0] {
        AVVIO    = 3'd0,
        RACCOLTA = 3'd1,
        GIOCA    = 3'd2,
        CATTURA  = 3'd3,
        USCITA   = 3'd4,
        FINE     = 3'd5
    } stato_t;

endpackage
`default_nettype wire

// File: rtl/sequenziatore_morra_if.sv
`default_nettype none
// ============================================================================
// Module   : sequenziatore_morra_if
// Brief    : Player, core and result signals of the morra sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface sequenziatore_morra_if;

    logic [1:0] MOSSA1;
    logic       VALIDO1;
    logic       PRESO1;
    logic [1:0] MOSSA2;
    logic       VALIDO2;
    logic       PRESO2;
    logic [1:0] PRIMO;
    logic [1:0] SECONDO;
    logic       CORE_INIZIA;
    logic [1:0] MANCHE;
    logic [1:0] PARTITA;
    logic [1:0] RIS_MANCHE;
    logic [1:0] RIS_PARTITA;
    logic       RIS_VALIDO;
    logic       RIS_PRONTO;
    logic [4:0] NUM_MANCHE;
    logic       SCADUTO;

    modport master (
        output MOSSA1, VALIDO1, MOSSA2, VALIDO2, MANCHE, PARTITA, RIS_PRONTO,
        input  PRESO1, PRESO2, PRIMO, SECONDO, CORE_INIZIA,
               RIS_MANCHE, RIS_PARTITA, RIS_VALIDO, NUM_MANCHE, SCADUTO
    );

    modport slave (
        input  MOSSA1, VALIDO1, MOSSA2, VALIDO2, MANCHE, PARTITA, RIS_PRONTO,
        output PRESO1, PRESO2, PRIMO, SECONDO, CORE_INIZIA,
               RIS_MANCHE, RIS_PARTITA, RIS_VALIDO, NUM_MANCHE, SCADUTO
    );

endinterface
`default_nettype wire

// File: rtl/slot_mossa.sv
`default_nettype none
// ============================================================================
// Module   : slot_mossa
// Brief    : One-entry player move holder with valid/accept handshake.
// Revision : 1.0 - initial release
// ============================================================================
module slot_mossa
    import morra_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_abilita,
    input  logic       i_valido,
    input  logic [1:0] i_mossa,
    input  logic       i_svuota,
    output logic       o_preso,
    output logic       o_carica,
    output logic       o_pieno,
    output logic [1:0] o_mossa
);

    logic       r_pieno;
    logic [1:0] r_mossa;

    // A "no move" is still handshaken, but never occupies the slot.
    always_comb begin
        o_preso  = i_abilita & i_valido & ~r_pieno;
        o_carica = o_preso & (i_mossa != NESSUNA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pieno <= 1'b0;
            r_mossa <= NESSUNA;
        end else if (i_svuota) begin
            r_pieno <= 1'b0;
            r_mossa <= NESSUNA;
        end else if (o_carica) begin
            r_pieno <= 1'b1;
            r_mossa <= i_mossa;
        end
    end

    assign o_pieno = r_pieno;
    assign o_mossa = r_mossa;

endmodule
`default_nettype wire

// File: rtl/sequenziatore_morra.sv
`default_nettype none
// ============================================================================
// Module   : sequenziatore_morra
// Brief    : Collects both players' moves, plays them on the MorraCinese core
//            and hands the captured result to a ready/valid consumer.
// Revision : 1.0 - initial release
// ============================================================================
module sequenziatore_morra
    import morra_pkg::*;
#(
    parameter int ATTESA_MAX = 255
)(
    input  logic                 clk,
    input  logic                 INIZIA,
    sequenziatore_morra_if.slave bus
);

    localparam int c_W_ATTESA = (ATTESA_MAX < 2) ? 1 : $clog2(ATTESA_MAX + 1);
    localparam logic [c_W_ATTESA-1:0] c_ATTESA_MAX = c_W_ATTESA'(ATTESA_MAX);
    localparam logic [c_W_ATTESA-1:0] c_UNO        = c_W_ATTESA'(1);

    stato_t                r_stato;
    stato_t                w_stato_pross;
    logic [c_W_ATTESA-1:0] r_attesa;
    logic [1:0]            r_ris_manche;
    logic [1:0]            r_ris_partita;
    logic [4:0]            r_num_manche;

    logic       w_raccolta;
    logic       w_uno_pieno;
    logic       w_scadenza;
    logic       w_cattura;
    logic       w_svuota1;
    logic       w_svuota2;
    logic       w_preso1;
    logic       w_preso2;
    logic       w_carica1;
    logic       w_carica2;
    logic       w_pieno1;
    logic       w_pieno2;
    logic [1:0] w_mossa1;
    logic [1:0] w_mossa2;

    slot_mossa u_slot1 (
        .clk       (clk),
        .rst       (INIZIA),
        .i_abilita (w_raccolta),
        .i_valido  (bus.VALIDO1),
        .i_mossa   (bus.MOSSA1),
        .i_svuota  (w_svuota1),
        .o_preso   (w_preso1),
        .o_carica  (w_carica1),
        .o_pieno   (w_pieno1),
        .o_mossa   (w_mossa1)
    );

    slot_mossa u_slot2 (
        .clk       (clk),
        .rst       (INIZIA),
        .i_abilita (w_raccolta),
        .i_valido  (bus.VALIDO2),
        .i_mossa   (bus.MOSSA2),
        .i_svuota  (w_svuota2),
        .o_preso   (w_preso2),
        .o_carica  (w_carica2),
        .o_pieno   (w_pieno2),
        .o_mossa   (w_mossa2)
    );

    // A late second move arriving on the deadline cycle beats the forfeit.
    always_comb begin
        w_raccolta  = (r_stato == RACCOLTA);
        w_cattura   = (r_stato == CATTURA);
        w_uno_pieno = w_raccolta & (w_pieno1 ^ w_pieno2);
        w_scadenza  = w_uno_pieno & (r_attesa == c_ATTESA_MAX) & ~(w_carica1 | w_carica2);
        w_svuota1   = w_cattura | (w_scadenza & w_pieno1);
        w_svuota2   = w_cattura | (w_scadenza & w_pieno2);
    end

    always_comb begin
        w_stato_pross = r_stato;
        case (r_stato)
            AVVIO:    w_stato_pross = RACCOLTA;
            RACCOLTA: if (w_pieno1 && w_pieno2) w_stato_pross = GIOCA;
            GIOCA:    w_stato_pross = CATTURA;
            CATTURA:  w_stato_pross = USCITA;
            USCITA: begin
                if (bus.RIS_PRONTO)
                    w_stato_pross = (r_ris_partita != c_PARTITA_IN_CORSO) ? FINE : RACCOLTA;
            end
            FINE:     w_stato_pross = FINE;
            default:  w_stato_pross = AVVIO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (INIZIA) r_stato <= AVVIO;
        else        r_stato <= w_stato_pross;
    end

    always_ff @(posedge clk) begin
        if (INIZIA || !w_uno_pieno || w_scadenza || w_carica1 || w_carica2)
            r_attesa <= '0;
        else
            r_attesa <= r_attesa + c_UNO;
    end

    always_ff @(posedge clk) begin
        if (INIZIA) begin
            r_ris_manche  <= MANCHE_NULLA;
            r_ris_partita <= c_PARTITA_IN_CORSO;
            r_num_manche  <= 5'd0;
        end else if (w_cattura) begin
            r_ris_manche  <= bus.MANCHE;
            r_ris_partita <= bus.PARTITA;
            if ((bus.MANCHE != MANCHE_NULLA) && (r_num_manche != c_MANCHE_SAT))
                r_num_manche <= r_num_manche + 5'd1;
        end
    end

    assign bus.PRESO1      = w_preso1;
    assign bus.PRESO2      = w_preso2;
    assign bus.PRIMO       = (r_stato == GIOCA) ? w_mossa1 : NESSUNA;
    assign bus.SECONDO     = (r_stato == GIOCA) ? w_mossa2 : NESSUNA;
    assign bus.CORE_INIZIA = (r_stato == AVVIO);
    assign bus.RIS_VALIDO  = (r_stato == USCITA);
    assign bus.RIS_MANCHE  = r_ris_manche;
    assign bus.RIS_PARTITA = r_ris_partita;
    assign bus.NUM_MANCHE  = r_num_manche;
    assign bus.SCADUTO     = w_scadenza;

endmodule
`default_nettype wire

// File: tb/tb_sequenziatore_morra.sv
`default_nettype none
// ============================================================================
// Module   : tb_sequenziatore_morra
// Brief    : Directed self-checking bench with a behavioral MorraCinese core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sequenziatore_morra;
    import morra_pkg::*;

    logic clk = 1'b0;
    logic INIZIA;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    sequenziatore_morra_if bus ();

    sequenziatore_morra #(.ATTESA_MAX(4)) dut (
        .clk    (clk),
        .INIZIA (INIZIA),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Behavioral core: first player to three round wins takes the game.
    logic [1:0] manche_m  = 2'b00;
    logic [1:0] partita_m = 2'b00;
    logic [1:0] vinte1    = 2'b00;
    logic [1:0] vinte2    = 2'b00;

    assign bus.MANCHE  = manche_m;
    assign bus.PARTITA = partita_m;

    function automatic logic [1:0] esito(input logic [1:0] a, input logic [1:0] b);
        if (a == b) return PAREGGIO;
        if ((a == SASSO && b == FORBICE) || (a == CARTA && b == SASSO) ||
            (a == FORBICE && b == CARTA)) return VINCE_P1;
        return VINCE_P2;
    endfunction

    always @(posedge clk) begin
        if (bus.CORE_INIZIA) begin
            manche_m  <= 2'b00;
            partita_m <= 2'b00;
            vinte1    <= 2'b00;
            vinte2    <= 2'b00;
        end else if (bus.PRIMO != 2'b00 && bus.SECONDO != 2'b00 && partita_m == 2'b00) begin
            manche_m <= esito(bus.PRIMO, bus.SECONDO);
            if (esito(bus.PRIMO, bus.SECONDO) == VINCE_P1) begin
                vinte1 <= vinte1 + 2'd1;
                if (vinte1 == 2'd2) partita_m <= 2'b01;
            end else if (esito(bus.PRIMO, bus.SECONDO) == VINCE_P2) begin
                vinte2 <= vinte2 + 2'd1;
                if (vinte2 == 2'd2) partita_m <= 2'b10;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mosse(input logic v1, input logic [1:0] m1, input logic v2, input logic [1:0] m2);
        bus.VALIDO1 = v1;
        bus.MOSSA1  = m1;
        bus.VALIDO2 = v2;
        bus.MOSSA2  = m2;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        INIZIA         = 1'b1;
        bus.RIS_PRONTO = 1'b1;
        mosse(0, 2'b00, 0, 2'b00);
        tick();
        tick();

        // Reset values, first cycle after release is AVVIO
        INIZIA = 1'b0;
        #1;
        chk("rst_core_inizia", 8'(bus.CORE_INIZIA), 8'd1);
        chk("rst_stato", 8'(dut.r_stato), 8'(AVVIO));
        chk("rst_num", 8'(bus.NUM_MANCHE), 8'd0);
        chk("rst_ris_manche", 8'(bus.RIS_MANCHE), 8'd0);
        chk("rst_ris_partita", 8'(bus.RIS_PARTITA), 8'd0);
        chk("rst_ris_valido", 8'(bus.RIS_VALIDO), 8'd0);
        chk("rst_scaduto", 8'(bus.SCADUTO), 8'd0);
        chk("rst_primo", 8'(bus.PRIMO), 8'd0);
        tick();
        chk("raccolta_core_inizia", 8'(bus.CORE_INIZIA), 8'd0);

        // Round 1: sasso vs forbice together
        mosse(1, SASSO, 1, FORBICE);
        chk("r1_preso1", 8'(bus.PRESO1), 8'd1);
        chk("r1_preso2", 8'(bus.PRESO2), 8'd1);
        tick();
        mosse(0, 2'b00, 0, 2'b00);
        chk("r1_primo_pre", 8'(bus.PRIMO), 8'd0);
        chk("r1_ris_valido_1", 8'(bus.RIS_VALIDO), 8'd0);
        tick();
        chk("r1_primo", 8'(bus.PRIMO), 8'(SASSO));
        chk("r1_secondo", 8'(bus.SECONDO), 8'(FORBICE));
        tick();
        chk("r1_primo_cattura", 8'(bus.PRIMO), 8'd0);
        chk("r1_ris_valido_2", 8'(bus.RIS_VALIDO), 8'd0);
        tick();
        chk("r1_ris_valido_3", 8'(bus.RIS_VALIDO), 8'd1);
        chk("r1_ris_manche", 8'(bus.RIS_MANCHE), 8'(VINCE_P1));
        chk("r1_num", 8'(bus.NUM_MANCHE), 8'd1);
        chk("r1_ris_partita", 8'(bus.RIS_PARTITA), 8'd0);
        tick();
        chk("r1_uscita_1ciclo", 8'(bus.RIS_VALIDO), 8'd0);

        // Round 2: carta, repeat while full, carta on the deadline cycle
        mosse(1, CARTA, 0, 2'b00);
        chk("r2_preso1", 8'(bus.PRESO1), 8'd1);
        tick();
        mosse(0, 2'b00, 0, 2'b00);
        tick();
        mosse(1, SASSO, 0, 2'b00);
        chk("r2_preso1_ripetuto", 8'(bus.PRESO1), 8'd0);
        tick();
        mosse(0, 2'b00, 0, 2'b00);
        tick();
        tick();
        mosse(0, 2'b00, 1, CARTA);
        chk("r2_preso2", 8'(bus.PRESO2), 8'd1);
        chk("r2_no_scaduto", 8'(bus.SCADUTO), 8'd0);
        tick();
        mosse(0, 2'b00, 0, 2'b00);
        tick();
        chk("r2_primo", 8'(bus.PRIMO), 8'(CARTA));
        chk("r2_secondo", 8'(bus.SECONDO), 8'(CARTA));
        tick();
        tick();
        chk("r2_ris_valido", 8'(bus.RIS_VALIDO), 8'd1);
        chk("r2_ris_manche", 8'(bus.RIS_MANCHE), 8'(PAREGGIO));
        chk("r2_num", 8'(bus.NUM_MANCHE), 8'd2);
        tick();

        // Forfeit: sasso alone waits out ATTESA_MAX
        mosse(1, SASSO, 0, 2'b00);
        tick();
        mosse(0, 2'b00, 0, 2'b00);
        tick();
        tick();
        tick();
        chk("f_scaduto_presto", 8'(bus.SCADUTO), 8'd0);
        tick();
        chk("f_scaduto", 8'(bus.SCADUTO), 8'd1);
        tick();
        chk("f_scaduto_impulso", 8'(bus.SCADUTO), 8'd0);
        chk("f_slot1_vuoto", 8'(dut.w_pieno1), 8'd0);
        chk("f_stato", 8'(dut.r_stato), 8'(RACCOLTA));
        mosse(1, NESSUNA, 0, 2'b00);
        chk("f_preso_nessuna", 8'(bus.PRESO1), 8'd1);
        tick();
        mosse(0, 2'b00, 0, 2'b00);
        chk("f_nessuna_scartata", 8'(dut.w_pieno1), 8'd0);
        chk("f_num", 8'(bus.NUM_MANCHE), 8'd2);

        // Round 3: carta vs sasso, consumer stalls six cycles
        bus.RIS_PRONTO = 1'b0;
        mosse(1, CARTA, 1, SASSO);
        tick();
        mosse(0, 2'b00, 0, 2'b00);
        tick();
        tick();
        tick();
        mosse(1, SASSO, 1, SASSO);
        for (int i = 0; i < 6; i++) begin
            chk("s_ris_valido", 8'(bus.RIS_VALIDO), 8'd1);
            chk("s_ris_manche", 8'(bus.RIS_MANCHE), 8'(VINCE_P1));
            chk("s_ris_partita", 8'(bus.RIS_PARTITA), 8'd0);
            chk("s_preso1", 8'(bus.PRESO1), 8'd0);
            chk("s_preso2", 8'(bus.PRESO2), 8'd0);
            tick();
        end
        mosse(0, 2'b00, 0, 2'b00);
        bus.RIS_PRONTO = 1'b1;
        #1;
        chk("s_ris_valido_fine", 8'(bus.RIS_VALIDO), 8'd1);
        chk("s_num", 8'(bus.NUM_MANCHE), 8'd3);
        tick();
        chk("s_rilascio", 8'(bus.RIS_VALIDO), 8'd0);
        chk("s_stato", 8'(dut.r_stato), 8'(RACCOLTA));

        // Round 4: forbice vs carta ends the game for player 1
        mosse(1, FORBICE, 1, CARTA);
        tick();
        mosse(0, 2'b00, 0, 2'b00);
        tick();
        tick();
        tick();
        chk("g_ris_manche", 8'(bus.RIS_MANCHE), 8'(VINCE_P1));
        chk("g_ris_partita", 8'(bus.RIS_PARTITA), 8'h01);
        chk("g_num", 8'(bus.NUM_MANCHE), 8'd4);
        tick();
        mosse(1, SASSO, 1, SASSO);
        chk("g_stato_fine", 8'(dut.r_stato), 8'(FINE));
        chk("g_preso1", 8'(bus.PRESO1), 8'd0);
        chk("g_preso2", 8'(bus.PRESO2), 8'd0);
        chk("g_ris_valido", 8'(bus.RIS_VALIDO), 8'd0);
        tick();
        tick();
        chk("g_fine_tiene_stato", 8'(dut.r_stato), 8'(FINE));
        chk("g_fine_tiene_num", 8'(bus.NUM_MANCHE), 8'd4);
        chk("g_fine_tiene_partita", 8'(bus.RIS_PARTITA), 8'h01);
        mosse(0, 2'b00, 0, 2'b00);
        INIZIA = 1'b1;
        tick();
        INIZIA = 1'b0;
        #1;
        chk("g_core_inizia", 8'(bus.CORE_INIZIA), 8'd1);
        chk("g_num_azzerato", 8'(bus.NUM_MANCHE), 8'd0);
        chk("g_partita_azzerata", 8'(bus.RIS_PARTITA), 8'd0);
        tick();
        chk("g_stato_raccolta", 8'(dut.r_stato), 8'(RACCOLTA));

        // Restart in the middle of GIOCA
        mosse(1, SASSO, 1, SASSO);
        tick();
        mosse(0, 2'b00, 0, 2'b00);
        tick();
        chk("m_primo_gioca", 8'(bus.PRIMO), 8'(SASSO));
        INIZIA = 1'b1;
        tick();
        INIZIA = 1'b0;
        #1;
        chk("m_primo", 8'(bus.PRIMO), 8'd0);
        chk("m_secondo", 8'(bus.SECONDO), 8'd0);
        chk("m_stato", 8'(dut.r_stato), 8'(AVVIO));
        chk("m_slot1", 8'(dut.w_pieno1), 8'd0);
        chk("m_slot2", 8'(dut.w_pieno2), 8'd0);
        chk("m_core_inizia", 8'(bus.CORE_INIZIA), 8'd1);
        tick();
        chk("m_stato_raccolta", 8'(dut.r_stato), 8'(RACCOLTA));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
